// File: rtl/wb_queue.sv
// Write-back queue between the victim buffer and the memory unit.
// Evicted dirty lines are pushed at the tail. The drain FSM presents the head
// entry to memory and retires it on mem2wb_ack. An optional forwarding path
// (macro WB_FORWARD_EN) lets an L1 miss pick up data that is still queued.
// With WB_FORWARD_EN undefined, lookup_hit/lookup_data are tied to zero.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef DATA_LENGTH
`define DATA_LENGTH 64
`endif
`ifndef BLOCK_LENGTH
`define BLOCK_LENGTH 3
`endif

module wb_queue #(
  parameter int unsigned WB_DEPTH = 4,
  parameter int unsigned WB_LEN   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    victim2wb_valid,
  input  logic [`XLEN-1:0]        victim2wb_addr,
  input  logic [`DATA_LENGTH-1:0] victim2wb_data,
  output logic                    wb_full,
  output logic                    wb_empty,
  output logic                    wb2mem_req,
  output logic [`XLEN-1:0]        wb2mem_addr,
  output logic [`DATA_LENGTH-1:0] wb2mem_data,
  input  logic                    mem2wb_ack,
  input  logic [`XLEN-1:0]        lookup_addr,
  output logic                    lookup_hit,
  output logic [`DATA_LENGTH-1:0] lookup_data,
  output logic [WB_LEN:0]         count
);

  localparam logic [WB_LEN:0] DepthCnt = WB_DEPTH[WB_LEN:0];

  typedef enum logic {StIdle, StReq} state_e;

  state_e                  state_q, state_d;
  logic [WB_LEN-1:0]       head_q, head_d;
  logic [WB_LEN-1:0]       tail_q, tail_d;
  logic [WB_LEN:0]         count_q, count_d;
  logic [WB_DEPTH-1:0]     valid_q, valid_d;
  logic [`XLEN-1:0]        addr_q [WB_DEPTH];
  logic [`DATA_LENGTH-1:0] data_q [WB_DEPTH];

  logic push;
  logic pop;

  // Status flags come straight from the registered occupancy.
  assign wb_full  = (count_q == DepthCnt);
  assign wb_empty = (count_q == '0);
  assign count    = count_q;

  // A push against a full queue is dropped even if a pop retires an entry
  // on the same edge; acks outside the request state are ignored.
  assign push = victim2wb_valid && !wb_full;
  assign pop  = (state_q == StReq) && mem2wb_ack;

  // Next-state for pointers, occupancy, valid bits and the drain FSM.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    valid_d = valid_q;
    count_d = count_q;
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + WB_LEN'(1);
    end
    if (push) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + WB_LEN'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Request whenever anything remains queued after this edge, so a push
    // into an idle queue raises wb2mem_req one cycle later.
    state_d = (count_d != '0) ? StReq : StIdle;
  end

  // Drain FSM and queue bookkeeping; reset wins over a same-cycle ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Entry payload storage; contents are only observed behind valid bits.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      addr_q[tail_q] <= victim2wb_addr;
      data_q[tail_q] <= victim2wb_data;
    end
  end

  // Head entry is presented while requesting and held until acknowledged.
  assign wb2mem_req  = (state_q == StReq);
  assign wb2mem_addr = wb2mem_req ? addr_q[head_q] : '0;
  assign wb2mem_data = wb2mem_req ? data_q[head_q] : '0;

`ifdef WB_FORWARD_EN
  logic [WB_LEN-1:0] lk_idx;
  logic              unused_lookup_lo;

  // Scan oldest to youngest so the entry closest to the tail wins.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    lk_idx      = head_q;
    for (int unsigned i = 0; i < WB_DEPTH; i++) begin
      lk_idx = head_q + WB_LEN'(i);
      if (valid_q[lk_idx] &&
          (addr_q[lk_idx][`XLEN-1:`BLOCK_LENGTH] == lookup_addr[`XLEN-1:`BLOCK_LENGTH])) begin
        lookup_hit  = 1'b1;
        lookup_data = data_q[lk_idx];
      end
    end
  end

  // Offset bits within a block never take part in the match.
  assign unused_lookup_lo = ^lookup_addr[`BLOCK_LENGTH-1:0];
`else
  logic unused_fwd;

  assign lookup_hit  = 1'b0;
  assign lookup_data = '0;
  assign unused_fwd  = ^{lookup_addr, valid_q};
`endif

`ifndef SYNTHESIS
  // Occupancy must never exceed depth and must agree with the valid bits.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (count_q <= DepthCnt)
        else $error("wb_queue: count exceeds depth");
      assert ($countones(valid_q) == int'(count_q))
        else $error("wb_queue: valid bits disagree with count");
    end
  end
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: directed scenarios plus random traffic,
// all compared every cycle against a queue-based reference model.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef DATA_LENGTH
`define DATA_LENGTH 64
`endif
`ifndef BLOCK_LENGTH
`define BLOCK_LENGTH 3
`endif

module tb_wb_queue;

  localparam int XL    = `XLEN;
  localparam int DL    = `DATA_LENGTH;
  localparam int BL    = `BLOCK_LENGTH;
  localparam int DEPTH = 4;
  localparam int LEN   = 2;

  typedef struct packed {
    logic [XL-1:0] a;
    logic [DL-1:0] d;
  } ent_t;

  logic          clk;
  logic          rst;
  logic          victim2wb_valid;
  logic [XL-1:0] victim2wb_addr;
  logic [DL-1:0] victim2wb_data;
  logic          wb_full;
  logic          wb_empty;
  logic          wb2mem_req;
  logic [XL-1:0] wb2mem_addr;
  logic [DL-1:0] wb2mem_data;
  logic          mem2wb_ack;
  logic [XL-1:0] lookup_addr;
  logic          lookup_hit;
  logic [DL-1:0] lookup_data;
  logic [LEN:0]  count;

  wb_queue #(
    .WB_DEPTH(DEPTH),
    .WB_LEN  (LEN)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .victim2wb_valid(victim2wb_valid),
    .victim2wb_addr (victim2wb_addr),
    .victim2wb_data (victim2wb_data),
    .wb_full        (wb_full),
    .wb_empty       (wb_empty),
    .wb2mem_req     (wb2mem_req),
    .wb2mem_addr    (wb2mem_addr),
    .wb2mem_data    (wb2mem_data),
    .mem2wb_ack     (mem2wb_ack),
    .lookup_addr    (lookup_addr),
    .lookup_hit     (lookup_hit),
    .lookup_data    (lookup_data),
    .count          (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: pending write-backs oldest first, plus request flag.
  ent_t m_q[$];
  bit   m_req = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic compare_all();
    logic [XL-1:0] ea;
    logic [DL-1:0] ed;
    logic          eh;
    logic [DL-1:0] eld;
    ea  = '0;
    ed  = '0;
    eh  = 1'b0;
    eld = '0;
    if (m_req) begin
      ea = m_q[0].a;
      ed = m_q[0].d;
    end
`ifdef WB_FORWARD_EN
    foreach (m_q[i]) begin
      if (m_q[i].a[XL-1:BL] == lookup_addr[XL-1:BL]) begin
        eh  = 1'b1;
        eld = m_q[i].d;
      end
    end
`endif
    check_eq("wb_full", 64'(wb_full), 64'(m_q.size() == DEPTH));
    check_eq("wb_empty", 64'(wb_empty), 64'(m_q.size() == 0));
    check_eq("count", 64'(count), 64'(m_q.size()));
    check_eq("wb2mem_req", 64'(wb2mem_req), 64'(m_req));
    check_eq("wb2mem_addr", 64'(wb2mem_addr), 64'(ea));
    check_eq("wb2mem_data", 64'(wb2mem_data), 64'(ed));
    check_eq("lookup_hit", 64'(lookup_hit), 64'(eh));
    check_eq("lookup_data", 64'(lookup_data), 64'(eld));
  endtask

  // Apply the spec's rules to the inputs present at this clock edge.
  task automatic model_step();
    bit do_push;
    bit do_pop;
    ent_t e;
    if (rst) begin
      m_q.delete();
    end else begin
      do_push = victim2wb_valid && (m_q.size() != DEPTH);
      do_pop  = m_req && mem2wb_ack;
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
        e.a = victim2wb_addr;
        e.d = victim2wb_data;
        m_q.push_back(e);
      end
    end
    m_req = (m_q.size() != 0);
  endtask

  // One clock: drive at negedge, compare, advance model at posedge, settle.
  task automatic drive(input logic r, input logic v, input logic [XL-1:0] a,
                       input logic [DL-1:0] d, input logic ak, input logic [XL-1:0] la);
    @(negedge clk);
    rst             = r;
    victim2wb_valid = v;
    victim2wb_addr  = a;
    victim2wb_data  = d;
    mem2wb_ack      = ak;
    lookup_addr     = la;
    #1;
    compare_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0);
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic push(input logic [XL-1:0] a, input logic [DL-1:0] d);
    drive(1'b0, 1'b1, a, d, 1'b0, '0);
  endtask

  initial begin
    rst             = 1'b1;
    victim2wb_valid = 1'b0;
    victim2wb_addr  = '0;
    victim2wb_data  = '0;
    mem2wb_ack      = 1'b0;
    lookup_addr     = '0;
    @(posedge clk);
    @(posedge clk);
    model_step();
    #1;

    // Reset state
    check_eq("rst_empty", 64'(wb_empty), 64'd1);
    check_eq("rst_req", 64'(wb2mem_req), 64'd0);
    check_eq("rst_count", 64'(count), 64'd0);

    // Single push, one-cycle latency, ack drains it
    do_reset();
    push(32'h100, 64'hAA);
    check_eq("t1_req", 64'(wb2mem_req), 64'd1);
    check_eq("t1_addr", 64'(wb2mem_addr), 64'h100);
    check_eq("t1_data", 64'(wb2mem_data), 64'hAA);
    drive(1'b0, 1'b0, '0, '0, 1'b1, '0);
    check_eq("t1_empty", 64'(wb_empty), 64'd1);
    check_eq("t1_idle", 64'(wb2mem_req), 64'd0);

    // Fill, overflow drop, drain in order
    do_reset();
    for (int k = 1; k <= 4; k++) push(XL'(k * 32'h100), DL'(k));
    check_eq("t2_full", 64'(wb_full), 64'd1);
    check_eq("t2_count", 64'(count), 64'd4);
    push(32'h500, 64'h5);
    check_eq("t2_drop", 64'(count), 64'd4);
    for (int k = 1; k <= 4; k++) begin
      check_eq("t2_order", 64'(wb2mem_addr), 64'(k * 32'h100));
      drive(1'b0, 1'b0, '0, '0, 1'b1, '0);
    end
    check_eq("t2_empty", 64'(wb_empty), 64'd1);

    // Full queue: push with ack is dropped, next push accepted
    do_reset();
    for (int k = 1; k <= 4; k++) push(XL'(k * 32'h100), DL'(k));
    drive(1'b0, 1'b1, 32'h600, 64'h6, 1'b1, '0);
    check_eq("t3_count3", 64'(count), 64'd3);
    push(32'h700, 64'h7);
    check_eq("t3_count4", 64'(count), 64'd4);
    check_eq("t3_head", 64'(wb2mem_addr), 64'h200);

    // Forwarding picks the youngest matching entry
    do_reset();
    push(32'h200, 64'h11);
    push(32'h200, 64'h22);
    drive(1'b0, 1'b0, '0, '0, 1'b0, 32'h204);
`ifdef WB_FORWARD_EN
    check_eq("t4_hit", 64'(lookup_hit), 64'd1);
    check_eq("t4_data", 64'(lookup_data), 64'h22);
`else
    check_eq("t4_hit", 64'(lookup_hit), 64'd0);
    check_eq("t4_data", 64'(lookup_data), 64'd0);
`endif

    // Pointer wrap: 6 pushes, 5 interleaved acks
    do_reset();
    push(32'h1000, 64'h1);
    for (int k = 2; k <= 6; k++) begin
      drive(1'b0, 1'b1, XL'(32'h1000 * k), DL'(k), 1'b1, '0);
    end
    check_eq("t5_count", 64'(count), 64'd1);
    check_eq("t5_head", 64'(wb2mem_addr), 64'h6000);

    // Reset during an acknowledged request
    do_reset();
    push(32'h300, 64'h33);
    drive(1'b1, 1'b0, '0, '0, 1'b1, '0);
    check_eq("t6_req", 64'(wb2mem_req), 64'd0);
    check_eq("t6_count", 64'(count), 64'd0);
    check_eq("t6_empty", 64'(wb_empty), 64'd1);

    // Random traffic over a small address pool so lookups hit often
    do_reset();
    for (int n = 0; n < 500; n++) begin
      logic          r;
      logic          v;
      logic          ak;
      logic [XL-1:0] a;
      logic [XL-1:0] la;
      logic [DL-1:0] d;
      r  = ($urandom_range(0, 59) == 0);
      v  = ($urandom_range(0, 99) < 55);
      ak = ($urandom_range(0, 99) < 45);
      a  = XL'(32'h4000 + ($urandom_range(0, 7) << BL));
      la = XL'(32'h4000 + ($urandom_range(0, 9) << BL) + $urandom_range(0, (1 << BL) - 1));
      d  = {32'($urandom), 32'($urandom)};
      drive(r, v, a, d, ak, la);
    end
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 Parameter WB_DEPTH, default 4, number of queue entries (power of two, >=2).
REQ-002 Parameter WB_LEN, default 2, index width, equal to log2(WB_DEPTH).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 victim2wb_valid  input  1  push request for an evicted dirty line (driven from victim-buffer wb_req).
REQ-006 victim2wb_addr  input  `XLEN  block-aligned write-back address.
REQ-007 victim2wb_data  input  `DATA_LENGTH  write-back line data.
REQ-008 wb_full  output  1  queue full; a push is refused while high.
REQ-009 wb_empty  output  1  queue holds no entries.
REQ-010 wb2mem_req  output  1  write request to the memory unit.
REQ-011 wb2mem_addr  output  `XLEN  head-entry address; valid while wb2mem_req is high.
REQ-012 wb2mem_data  output  `DATA_LENGTH  head-entry data; valid while wb2mem_req is high.
REQ-013 mem2wb_ack  input  1  single-cycle pulse: memory accepted the current request.
REQ-014 lookup_addr  input  `XLEN  L1 miss address to check against pending write-backs.
REQ-015 lookup_hit  output  1  combinational: a valid entry matches lookup_addr (block-aligned compare).
REQ-016 lookup_data  output  `DATA_LENGTH  data of the youngest matching entry; 0 when no hit.
REQ-017 count  output  WB_LEN+1  number of occupied entries.

Function
REQ-018 Storage is a circular FIFO: head pointer, tail pointer, count, per-entry valid/addr/data.
REQ-019 Push is accepted at posedge when victim2wb_valid && !wb_full; the entry is written at tail, tail increments modulo WB_DEPTH.
REQ-020 Push while wb_full is dropped with no state change, even if mem2wb_ack pops in the same cycle.
REQ-021 wb_full = (count == WB_DEPTH); wb_empty = (count == 0); both derived from registered count.
REQ-022 Drain FSM has states IDLE and REQ; wb2mem_req is high exactly in REQ.
REQ-023 IDLE -> REQ at posedge when count != 0 (including an entry pushed that same edge, visible the next cycle).
REQ-024 In REQ, wb2mem_addr/data hold the head entry unchanged until mem2wb_ack.
REQ-025 On mem2wb_ack in REQ: head entry invalidated, head increments modulo WB_DEPTH; next state is REQ if remaining count != 0, else IDLE.
REQ-026 mem2wb_ack in IDLE is ignored.
REQ-027 Push and pop in the same cycle (not full): count unchanged, both pointers advance.
REQ-028 Minimum latency push -> wb2mem_req is one cycle; back-to-back acks drain one entry per cycle.
REQ-029 Lookup compares addr[`XLEN-1:`BLOCK_LENGTH] over all valid entries, including the in-flight head; the youngest match (closest to tail) wins.
REQ-030 An entry pushed on the current edge is not visible to lookup until the following cycle.

Reset
REQ-031 While rst is high at posedge: head, tail, count = 0; all valid = 0; FSM = IDLE.
REQ-032 Reset values: wb2mem_req = 0, wb_full = 0, wb_empty = 1, count = 0, lookup_hit = 0, lookup_data = 0, wb2mem_addr/data = 0.
REQ-033 Reset mid-transfer abandons the in-flight request; a mem2wb_ack arriving in the same cycle as rst is ignored.

Configuration
REQ-034 Macro WB_FORWARD_EN: when defined, lookup_hit/lookup_data behave per REQ-029/030.
REQ-035 When WB_FORWARD_EN is undefined, lookup_hit and lookup_data are tied to 0, no comparators are built, and lookup_addr is unused.

Verification
REQ-036 Reset, then push addr 0x100 data 0xAA -> next cycle wb2mem_req=1, addr 0x100, data 0xAA; ack -> wb_empty=1, FSM IDLE.
REQ-037 Four pushes with no ack (WB_DEPTH=4) -> wb_full=1, count=4; fifth push 0x500 dropped; drain returns 4 entries in push order.
REQ-038 Full queue, push and ack in the same cycle -> push dropped, count=3; next push accepted, count=4.
REQ-039 Push 0x200/0x11 then 0x200/0x22; lookup 0x204 -> lookup_hit=1, lookup_data=0x22 (0 with WB_FORWARD_EN undefined).
REQ-040 Pushes cross pointer wrap (6 pushes, 5 acks interleaved) -> FIFO order preserved, count=1 at end.
REQ-041 rst asserted while wb2mem_req=1 with ack the same cycle -> next cycle wb2mem_req=0, count=0, wb_empty=1.
